muldiv_unit: RTL and testbench



---
 rtl/muldiv_unit.sv | 180 ++++++++++++++++++
 tb/tb_muldiv_unit.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Radix-2 iterative multiply/divide unit: shift-add multiply, restoring divide, one bit per clock.
// Define MULDIV_SIGNED_EN to enable two's-complement MULS/DIVS; otherwise op[0] is ignored.
module muldiv_unit #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi,
  output logic             divide_by_zero
);

  localparam int unsigned CNT_W  = $clog2(WIDTH + 1);
  localparam int unsigned PROD_W = 2 * WIDTH;
  localparam int unsigned ACC_W  = 2 * WIDTH + 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_FINISH = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] count_q;
  logic [ACC_W-1:0] acc_q;
  logic [WIDTH-1:0] opb_q;
  logic [WIDTH-1:0] a_q;
  logic             is_div_q;
`ifdef MULDIV_SIGNED_EN
  logic             neg_res_q;
  logic             neg_rem_q;
`endif

  logic             signed_c;
  logic [WIDTH-1:0] mag_a_c, mag_b_c;
  logic             div_zero_c;
  logic             last_iter_c;
  logic [WIDTH:0]   mul_sum_c;
  logic [ACC_W-1:0] mul_next_c;
  logic [ACC_W-1:0] div_shift_c;
  logic [WIDTH:0]   div_trial_c;
  logic [ACC_W-1:0] div_next_c;
  logic [PROD_W-1:0] prod_c;
  logic [WIDTH-1:0] quot_c, rem_c;
  logic [WIDTH-1:0] res_lo_c, res_hi_c;

  // Operand magnitudes captured at start; signed ops work on |a|, |b|
  always_comb begin
    signed_c = 1'b0;
`ifdef MULDIV_SIGNED_EN
    signed_c = op[0];
`endif
    mag_a_c = (signed_c && a[WIDTH-1]) ? (~a + WIDTH'(1)) : a;
    mag_b_c = (signed_c && b[WIDTH-1]) ? (~b + WIDTH'(1)) : b;
  end

`ifndef MULDIV_SIGNED_EN
  logic op0_unused;
  assign op0_unused = op[0];
`endif

  assign div_zero_c  = is_div_q && (opb_q == '0) && (count_q == '0);
  assign last_iter_c = (count_q == CNT_W'(WIDTH - 1));

  // One multiply step: conditional add into the upper half, then shift right
  always_comb begin
    mul_sum_c  = acc_q[ACC_W-1:WIDTH] + {1'b0, opb_q};
    mul_next_c = acc_q[0] ? {1'b0, mul_sum_c, acc_q[WIDTH-1:1]}
                          : {1'b0, acc_q[ACC_W-1:1]};
  end

  // One restoring divide step: shift left, keep the trial subtract if it did not borrow
  always_comb begin
    div_shift_c = {acc_q[ACC_W-2:0], 1'b0};
    div_trial_c = div_shift_c[ACC_W-1:WIDTH] - {1'b0, opb_q};
    div_next_c  = (div_shift_c[ACC_W-1:WIDTH] >= {1'b0, opb_q})
                ? {div_trial_c, div_shift_c[WIDTH-1:1], 1'b1}
                : div_shift_c;
  end

  // Result selection with sign fixups
  always_comb begin
    prod_c = acc_q[PROD_W-1:0];
    quot_c = acc_q[WIDTH-1:0];
    rem_c  = acc_q[PROD_W-1:WIDTH];
`ifdef MULDIV_SIGNED_EN
    if (neg_res_q) begin
      prod_c = ~prod_c + PROD_W'(1);
      quot_c = ~quot_c + WIDTH'(1);
    end
    if (neg_rem_q) begin
      rem_c = ~rem_c + WIDTH'(1);
    end
`endif
    res_lo_c = is_div_q ? quot_c : prod_c[WIDTH-1:0];
    res_hi_c = is_div_q ? rem_c  : prod_c[PROD_W-1:WIDTH];
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_RUN;
      end
      S_RUN: begin
        if (div_zero_c)       state_d = S_IDLE;
        else if (last_iter_c) state_d = S_FINISH;
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      busy           <= 1'b0;
      done           <= 1'b0;
      result_lo      <= '0;
      result_hi      <= '0;
      divide_by_zero <= 1'b0;
      count_q        <= '0;
      acc_q          <= '0;
      opb_q          <= '0;
      a_q            <= '0;
      is_div_q       <= 1'b0;
`ifdef MULDIV_SIGNED_EN
      neg_res_q      <= 1'b0;
      neg_rem_q      <= 1'b0;
`endif
    end else begin
      busy <= (state_d != S_IDLE);
      done <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            a_q            <= a;
            opb_q          <= mag_b_c;
            acc_q          <= {(WIDTH + 1)'(0), mag_a_c};
            is_div_q       <= op[1];
            count_q        <= '0;
            divide_by_zero <= 1'b0;
`ifdef MULDIV_SIGNED_EN
            neg_res_q      <= signed_c && (a[WIDTH-1] ^ b[WIDTH-1]);
            neg_rem_q      <= signed_c && op[1] && a[WIDTH-1];
`endif
          end
        end
        S_RUN: begin
          if (div_zero_c) begin
            result_lo      <= '1;
            result_hi      <= a_q;
            divide_by_zero <= 1'b1;
            done           <= 1'b1;
          end else begin
            acc_q   <= is_div_q ? div_next_c : mul_next_c;
            count_q <= count_q + CNT_W'(1);
          end
        end
        S_FINISH: begin
          result_lo <= res_lo_c;
          result_hi <= res_hi_c;
          done      <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit (WIDTH=16); expectations follow MULDIV_SIGNED_EN.
module tb_muldiv_unit;

  logic        clock;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [15:0] a, b;
  logic        busy, done, divide_by_zero;
  logic [15:0] result_lo, result_hi;

  int tests_run = 0;
  int tests_failed = 0;

  muldiv_unit #(.WIDTH(16)) dut (
    .clock          (clock),
    .reset          (reset),
    .start          (start),
    .op             (op),
    .a              (a),
    .b              (b),
    .busy           (busy),
    .done           (done),
    .result_lo      (result_lo),
    .result_hi      (result_hi),
    .divide_by_zero (divide_by_zero)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Present an operation at the negedge; returns just after the accepting edge E0
  task automatic issue(input logic [1:0] o, input logic [15:0] x, input logic [15:0] y);
    @(negedge clock);
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
  endtask

  // Counts edges after E0 until done is seen; bounded
  task automatic wait_done(output int lat);
    lat = 0;
    while (!done && lat < 100) begin
      @(posedge clock); #1;
      lat++;
    end
  endtask

  task automatic do_op(input logic [1:0] o, input logic [15:0] x, input logic [15:0] y,
                       output int lat);
    issue(o, x, y);
    wait_done(lat);
  endtask

  int lat;
  int done_seen;

  initial begin
    reset = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
    repeat (2) @(posedge clock);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_lo",   32'(result_lo), 32'd0);
    check("rst_hi",   32'(result_hi), 32'd0);
    check("rst_dbz",  32'(divide_by_zero), 32'd0);
    @(negedge clock);
    reset = 1'b0;

    // MULU max * max
    issue(2'b00, 16'hFFFF, 16'hFFFF);
    check("mulu_busy_e0", 32'(busy), 32'd1);
    wait_done(lat);
    check("mulu_lat",  32'(lat), 32'd17);
    check("mulu_hi",   32'(result_hi), 32'h0000_FFFE);
    check("mulu_lo",   32'(result_lo), 32'h0000_0001);
    check("mulu_busy", 32'(busy), 32'd0);

    // DIVU 100/7
    do_op(2'b10, 16'd100, 16'd7, lat);
    check("divu_lat", 32'(lat), 32'd17);
    check("divu_q",   32'(result_lo), 32'd14);
    check("divu_r",   32'(result_hi), 32'd2);
    check("divu_dbz", 32'(divide_by_zero), 32'd0);

    // DIVU by zero
    do_op(2'b10, 16'h1234, 16'h0000, lat);
    check("dbz_lat", 32'(lat), 32'd1);
    check("dbz_lo",  32'(result_lo), 32'h0000_FFFF);
    check("dbz_hi",  32'(result_hi), 32'h0000_1234);
    check("dbz_flag", 32'(divide_by_zero), 32'd1);

    // MULS -3 * 5
    do_op(2'b01, 16'hFFFD, 16'd5, lat);
    check("muls_lat", 32'(lat), 32'd17);
    check("muls_dbz_clr", 32'(divide_by_zero), 32'd0);
`ifdef MULDIV_SIGNED_EN
    check("muls_hi", 32'(result_hi), 32'h0000_FFFF);
`else
    check("muls_hi", 32'(result_hi), 32'h0000_0004);
`endif
    check("muls_lo", 32'(result_lo), 32'h0000_FFF1);

    // DIVS -7 / 2
    do_op(2'b11, 16'hFFF9, 16'd2, lat);
`ifdef MULDIV_SIGNED_EN
    check("divs_q", 32'(result_lo), 32'h0000_FFFD);
    check("divs_r", 32'(result_hi), 32'h0000_FFFF);
`else
    check("divs_q", 32'(result_lo), 32'h0000_7FFC);
    check("divs_r", 32'(result_hi), 32'h0000_0001);
`endif

    // DIVS MIN / -1
    do_op(2'b11, 16'h8000, 16'hFFFF, lat);
    check("divs_min_lat", 32'(lat), 32'd17);
`ifdef MULDIV_SIGNED_EN
    check("divs_min_q", 32'(result_lo), 32'h0000_8000);
    check("divs_min_r", 32'(result_hi), 32'h0000_0000);
`else
    check("divs_min_q", 32'(result_lo), 32'h0000_0000);
    check("divs_min_r", 32'(result_hi), 32'h0000_8000);
`endif
    check("divs_min_dbz", 32'(divide_by_zero), 32'd0);

    // MULU 3*4 with a stray start at E5 that must be ignored
    issue(2'b00, 16'd3, 16'd4);
    repeat (4) @(posedge clock);
    @(negedge clock);
    a = 16'd9; b = 16'd9; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    check("ign_busy", 32'(busy), 32'd1);
    lat = 5;
    while (!done && lat < 100) begin
      @(posedge clock); #1;
      lat++;
    end
    check("ign_lat", 32'(lat), 32'd17);
    check("ign_lo",  32'(result_lo), 32'd12);
    check("ign_hi",  32'(result_hi), 32'd0);

    // Start in the done cycle; previous results hold until the new FINISH
    issue(2'b00, 16'd5, 16'd6);
    check("b2b_busy", 32'(busy), 32'd1);
    check("b2b_hold", 32'(result_lo), 32'd12);
    wait_done(lat);
    check("b2b_lat", 32'(lat), 32'd17);
    check("b2b_lo",  32'(result_lo), 32'd30);

    // Reset at E8 of DIVU 1000/3
    issue(2'b10, 16'd1000, 16'd3);
    repeat (7) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_lo",   32'(result_lo), 32'd0);
    check("mid_rst_hi",   32'(result_hi), 32'd0);
    done_seen = 0;
    check("mid_rst_done", 32'(done), 32'd0);
    for (int i = 0; i < 20; i++) begin
      @(posedge clock); #1;
      if (done) done_seen++;
    end
    check("mid_rst_nodone", 32'(done_seen), 32'd0);

    do_op(2'b10, 16'd1000, 16'd3, lat);
    check("div1000_lat", 32'(lat), 32'd17);
    check("div1000_q",   32'(result_lo), 32'd333);
    check("div1000_r",   32'(result_hi), 32'd1);

    @(posedge clock); #1;
    check("done_pulse_len", 32'(done), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
